// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: ALU op select, datapath enables,
// memory handshake, branch resolution and overflow/illegal traps.
module mips_multicycle_ctrl #(
  parameter bit EXC_ON_UNSIGNED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic       overflow,
  output logic [3:0] opselect,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pc_en,
  output logic [1:0] pcsource,
  output logic       exception,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REXEC, S_IEXEC,
    S_RWB, S_IWB, S_MEMADDR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_rop;
  logic       w_rvalid;
  logic [3:0] w_iop;
  logic [3:0] w_wbop;
  logic       w_ovf_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_rop    = 4'b0000;
    w_rvalid = 1'b1;
    case (funct)
      6'h20:   w_rop = 4'b0100;
      6'h21:   w_rop = 4'b1100;
      6'h22:   w_rop = 4'b0101;
      6'h23:   w_rop = 4'b1101;
      6'h24:   w_rop = 4'b0110;
      6'h25:   w_rop = 4'b0010;
      6'h27:   w_rop = 4'b0011;
      6'h2A:   w_rop = 4'b0111;
      6'h2B:   w_rop = 4'b1111;
      6'h00:   w_rop = 4'b0000;
      6'h02:   w_rop = 4'b0001;
      default: w_rvalid = 1'b0;
    endcase
  end

  always_comb begin
    w_iop = 4'b0000;
    case (opcode)
      6'h08:   w_iop = 4'b0100;
      6'h09:   w_iop = 4'b1100;
      6'h0A:   w_iop = 4'b0111;
      6'h0B:   w_iop = 4'b1111;
      6'h0C:   w_iop = 4'b0110;
      6'h0D:   w_iop = 4'b0010;
      default: w_iop = 4'b0000;
    endcase
  end

  // Signed add/sub always trap; unsigned arithmetic only when enabled.
  assign w_wbop     = (r_state == S_RWB) ? w_rop : w_iop;
  assign w_ovf_trap = overflow &&
    ((w_wbop[3:1] == 3'b010) ||
     (EXC_ON_UNSIGNED &&
      (w_wbop == 4'b1100 || w_wbop == 4'b1101 ||
       w_wbop == 4'b1111)));

  always_comb begin
    w_next     = r_state;
    opselect   = 4'b0000;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pc_en      = 1'b0;
    pcsource   = 2'b00;
    exception  = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        memread  = 1'b1;
        irwrite  = mem_ready;
        alusrcb  = 2'b01;
        opselect = 4'b1100;
        pc_en    = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb  = 2'b11;
        opselect = 4'b1100;
        case (opcode)
          OP_R:           w_next = S_REXEC;
          OP_LW, OP_SW:   w_next = S_MEMADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          6'h08, 6'h09, 6'h0A,
          6'h0B, 6'h0C, 6'h0D: w_next = S_IEXEC;
          default:        w_next = S_TRAP;
        endcase
      end
      S_REXEC: begin
        alusrca  = 1'b1;
        opselect = w_rop;
        w_next   = w_rvalid ? S_RWB : S_TRAP;
      end
      S_IEXEC: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        opselect = w_iop;
        w_next   = S_IWB;
      end
      S_RWB, S_IWB: begin
        opselect   = w_wbop;
        regdst     = (r_state == S_RWB);
        instr_done = 1'b1;
        regwrite   = !w_ovf_trap;
        exception  = w_ovf_trap;
        pc_en      = w_ovf_trap;
        pcsource   = w_ovf_trap ? 2'b11 : 2'b00;
        w_next     = S_FETCH;
      end
      S_MEMADDR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        opselect = 4'b1100;
        w_next   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        opselect   = 4'b0101;
        pcsource   = 2'b01;
        instr_done = 1'b1;
        pc_en      = (opcode == OP_BEQ) ? zero : !zero;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_en      = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        exception  = 1'b1;
        pc_en      = 1'b1;
        pcsource   = 2'b11;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected cycle
// sequences from the ISA tables, compared on every falling edge.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready, zero, overflow;
  logic [3:0] opselect;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord, memread, memwrite, irwrite, regwrite;
  logic       regdst, memtoreg, pc_en;
  logic [1:0] pcsource;
  logic       exception, instr_done;

  typedef struct packed {
    logic [3:0] op;
    logic       asa;
    logic [1:0] asb;
    logic       iord, mr, mw, irw, rw, rd, m2r, pcen;
    logic [1:0] pcs;
    logic       exc, done;
  } o_t;

  o_t got, exp_o;
  bit exp_valid = 0;
  bit first_c = 0;
  int lat_exp = 0;
  int lat_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero), .overflow(overflow),
    .opselect(opselect), .alusrca(alusrca), .alusrcb(alusrcb),
    .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .pc_en(pc_en), .pcsource(pcsource),
    .exception(exception), .instr_done(instr_done)
  );

  assign got = {opselect, alusrca, alusrcb, iord, memread, memwrite,
                irwrite, regwrite, regdst, memtoreg, pc_en, pcsource,
                exception, instr_done};

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL cycle @%0t op=%h fn=%h: got %b required %b",
                 $time, opcode, funct, got, exp_o);
      end
      lat_cnt = first_c ? 1 : lat_cnt + 1;
      if (instr_done === 1'b1 && lat_exp != 0) begin
        checks++;
        if (lat_cnt != lat_exp) begin
          errors++;
          $display("FAIL latency op=%h: got %0d required %0d",
                   opcode, lat_cnt, lat_exp);
        end
      end
    end
  end

  function automatic logic rb();
    int v;
    v = $urandom_range(1, 0);
    return v[0];
  endfunction

  function automatic int r_op(input logic [5:0] f);
    case (f)
      6'h20: return 4;   6'h21: return 12;
      6'h22: return 5;   6'h23: return 13;
      6'h24: return 6;   6'h25: return 2;
      6'h27: return 3;   6'h2A: return 7;
      6'h2B: return 15;  6'h00: return 0;
      6'h02: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int i_op(input logic [5:0] o);
    case (o)
      6'h08: return 4;   6'h09: return 12;
      6'h0A: return 7;   6'h0B: return 15;
      6'h0C: return 6;   6'h0D: return 2;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string nm, input o_t g, input o_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, g, e);
    end
  endtask

  task automatic cyc(input o_t e, input logic mr, input logic z,
                     input logic ov, input bit first);
    mem_ready = mr; zero = z; overflow = ov;
    exp_o = e; first_c = first; exp_valid = 1;
    @(posedge clk); #1;
  endtask

  task automatic wb(input int opv, input bit signed_op,
                    input logic rd, input logic ov);
    o_t e;
    e = '0; e.op = opv[3:0]; e.rd = rd; e.done = 1;
    if (signed_op && ov) begin
      e.exc = 1; e.pcen = 1; e.pcs = 2'b11;
    end else e.rw = 1;
    cyc(e, rb(), rb(), ov, 0);
  endtask

  task automatic trap_c();
    o_t e;
    e = '0; e.exc = 1; e.pcen = 1; e.pcs = 2'b11; e.done = 1;
    cyc(e, rb(), rb(), rb(), 0);
  endtask

  task automatic fetch_dec(input int fst);
    o_t e;
    e = '0; e.mr = 1; e.asb = 2'b01; e.op = 4'hC;
    for (int i = 0; i < fst; i++) cyc(e, 0, rb(), rb(), i == 0);
    e.irw = 1; e.pcen = 1;
    cyc(e, 1, rb(), rb(), fst == 0);
    e = '0; e.asb = 2'b11; e.op = 4'hC;
    cyc(e, rb(), rb(), rb(), 0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fst, input int mst,
                           input logic z, input logic ov,
                           input int lat);
    o_t e;
    int v;
    opcode = op; funct = fn; lat_exp = lat;
    fetch_dec(fst);
    e = '0;
    if (op == 6'h00) begin
      v = r_op(fn);
      e.asa = 1; e.op = (v < 0) ? 4'h0 : v[3:0];
      cyc(e, rb(), rb(), rb(), 0);
      if (v < 0) trap_c();
      else wb(v, fn == 6'h20 || fn == 6'h22, 1, ov);
    end else if (i_op(op) >= 0) begin
      v = i_op(op);
      e.asa = 1; e.asb = 2'b10; e.op = v[3:0];
      cyc(e, rb(), rb(), rb(), 0);
      wb(v, op == 6'h08, 0, ov);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e.asa = 1; e.asb = 2'b10; e.op = 4'hC;
      cyc(e, rb(), rb(), rb(), 0);
      e = '0; e.iord = 1;
      if (op == 6'h23) e.mr = 1; else e.mw = 1;
      for (int i = 0; i < mst; i++) cyc(e, 0, rb(), rb(), 0);
      if (op == 6'h2B) e.done = 1;
      cyc(e, 1, rb(), rb(), 0);
      if (op == 6'h23) begin
        e = '0; e.rw = 1; e.m2r = 1; e.done = 1;
        cyc(e, rb(), rb(), rb(), 0);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e.asa = 1; e.op = 4'b0101; e.pcs = 2'b01; e.done = 1;
      e.pcen = (op == 6'h04) ? z : !z;
      cyc(e, rb(), z, rb(), 0);
    end else if (op == 6'h02) begin
      e.pcen = 1; e.pcs = 2'b10; e.done = 1;
      cyc(e, rb(), rb(), rb(), 0);
    end else trap_c();
    lat_exp = 0;
  endtask

  task automatic idle_cyc();
    cyc('0, rb(), rb(), rb(), 0);
  endtask

  task automatic rand_instr();
    logic [5:0] ops [16];
    logic [5:0] fns [13];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h3F, 6'h00};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h3F, 6'h00};
    op = ops[$urandom_range(15, 0)];
    if ($urandom_range(9, 0) == 0) op = 6'($urandom);
    fn = fns[$urandom_range(12, 0)];
    if ($urandom_range(9, 0) == 0) fn = 6'($urandom);
    run_instr(op, fn, $urandom_range(2, 0), $urandom_range(3, 0),
              rb(), rb(), 0);
  endtask

  task automatic reset_mid_sw();
    o_t e;
    opcode = 6'h2B; funct = 6'h00;
    fetch_dec(0);
    e = '0; e.asa = 1; e.asb = 2'b10; e.op = 4'hC;
    cyc(e, rb(), rb(), rb(), 0);
    e = '0; e.iord = 1; e.mw = 1;
    mem_ready = 0; exp_o = e; first_c = 0; exp_valid = 1;
    @(negedge clk); #1;
    exp_valid = 0;
    rst_n = 0;
    #1;
    check("async reset mid-MEMWRITE", got, '0);
    mem_ready = 1;
    @(posedge clk); #1;
    check("held reset, no memwrite", got, '0);
    rst_n = 1;
    idle_cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; opcode = 0; funct = 0;
    mem_ready = 0; zero = 0; overflow = 0;
    #1;
    check("reset outputs", got, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset after edges", got, '0);
    rst_n = 1;
    idle_cyc();
    // Directed cases with pinned latencies.
    run_instr(6'h00, 6'h20, 0, 0, 0, 0, 4);
    run_instr(6'h23, 6'h00, 0, 3, 0, 0, 8);
    run_instr(6'h2B, 6'h00, 0, 0, 0, 0, 4);
    run_instr(6'h04, 6'h00, 0, 0, 1, 0, 3);
    run_instr(6'h05, 6'h00, 0, 0, 1, 0, 3);
    run_instr(6'h02, 6'h00, 0, 0, 0, 0, 3);
    run_instr(6'h00, 6'h20, 0, 0, 0, 1, 4);
    run_instr(6'h00, 6'h21, 0, 0, 0, 1, 4);
    run_instr(6'h08, 6'h00, 0, 0, 0, 1, 4);
    run_instr(6'h09, 6'h00, 0, 0, 0, 1, 4);
    run_instr(6'h3F, 6'h00, 0, 0, 0, 0, 3);
    run_instr(6'h00, 6'h3F, 0, 0, 0, 0, 4);
    run_instr(6'h00, 6'h22, 2, 0, 0, 1, 6);
    for (int i = 0; i < 300; i++) rand_instr();
    reset_mid_sw();
    for (int i = 0; i < 40; i++) rand_instr();
    exp_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
